// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace-capture stage.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALTED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
  } trace_rec_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;
  localparam int          REC_W    = $bits(trace_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  // Empty head reads as zero so the outputs have a defined reset value.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; occupancy lives in the pointers, so stale data is never exposed.
  always_ff @(posedge CLK) begin
    if (w_wr_en && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures one retire record per cycle into a FIFO, detects a self-loop halt,
// and tracks records dropped while the FIFO is full.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [31:0]            pc_q,
  input  logic [31:0]            pc_d,
  input  logic [31:0]            inst,
  input  logic [31:0]            alu_result,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_pc,
  output logic [31:0]            trace_inst,
  output logic [31:0]            trace_alu,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            dropped,
  output logic                   halted
);

  localparam int HC_W = $clog2(HALT_CYCLES + 1);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALT_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(HALT_CYCLES);

  state_t          r_state;
  logic            r_halted;
  logic [HC_W-1:0] r_hc;
  logic            r_overflow;
  logic [15:0]     r_dropped;

  trace_rec_t w_wr_rec;
  trace_rec_t w_rd_rec;
  logic       w_capturing;
  logic       w_match;
  logic       w_halt_hit;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;

  assign w_wr_rec.pc   = pc_q;
  assign w_wr_rec.inst = inst;
  assign w_wr_rec.alu  = alu_result;

  assign w_capturing = (r_state == CAPTURE);
  assign w_match     = (pc_d == pc_q);
  // The cycle that would bring hc to HALT_CYCLES halts instead of pushing.
  assign w_halt_hit  = w_capturing && w_match && (r_hc == HC_LAST);
  assign w_push      = w_capturing && !w_halt_hit;
  assign w_pop       = trace_ready && !w_empty;
  assign w_drop      = w_push && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_clr   (clear),
    .i_push  (w_push),
    .i_data  (w_wr_rec),
    .i_pop   (trace_ready),
    .o_data  (w_rd_rec),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_halted <= 1'b0;
      r_hc     <= '0;
    end else if (clear) begin
      r_state  <= IDLE;
      r_halted <= 1'b0;
      r_hc     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hc <= '0;
          if (start) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (w_halt_hit) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
            r_hc     <= HC_MAX;
          end else if (w_match) begin
            r_hc <= r_hc + HC_ONE;
          end else begin
            r_hc <= '0;
          end
        end
        HALTED: r_halted <= 1'b1;
        default: begin
          r_state  <= IDLE;
          r_halted <= 1'b0;
          r_hc     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropped != DROP_MAX) r_dropped <= r_dropped + 16'd1;
    end
  end

  assign trace_valid = !w_empty;
  assign trace_pc    = w_rd_rec.pc;
  assign trace_inst  = w_rd_rec.inst;
  assign trace_alu   = w_rd_rec.alu;
  assign overflow    = r_overflow;
  assign dropped     = r_dropped;
  assign halted      = r_halted;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer: capture, halt, overflow, clear, async reset.
module tb_cpu_trace_buffer;

  localparam int DEPTH       = 16;
  localparam int HALT_CYCLES = 4;

  logic        CLK;
  logic        Reset;
  logic        start;
  logic        clear;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] inst;
  logic [31:0] alu_result;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic [31:0] trace_alu;
  logic [$clog2(DEPTH):0] count;
  logic        overflow;
  logic [15:0] dropped;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_trace_buffer #(
    .DEPTH       (DEPTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .start       (start),
    .clear       (clear),
    .pc_q        (pc_q),
    .pc_d        (pc_d),
    .inst        (inst),
    .alu_result  (alu_result),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_pc    (trace_pc),
    .trace_inst  (trace_inst),
    .trace_alu   (trace_alu),
    .count       (count),
    .overflow    (overflow),
    .dropped     (dropped),
    .halted      (halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Records are tagged by pc: inst = 0x1300_<pc[15:0]>, alu = pc + 0x1000.
  task automatic step(input logic st, input logic cl, input logic [31:0] pq,
                      input logic [31:0] pd, input logic rdy);
    start       = st;
    clear       = cl;
    pc_q        = pq;
    pc_d        = pd;
    inst        = {16'h1300, pq[15:0]};
    alu_result  = pq + 32'h1000;
    trace_ready = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},    32'(trace_valid), 32'd0);
    check({tag, "_count"},    32'(count),       32'd0);
    check({tag, "_overflow"}, 32'(overflow),    32'd0);
    check({tag, "_dropped"},  32'(dropped),     32'd0);
    check({tag, "_halted"},   32'(halted),      32'd0);
    check({tag, "_pc"},       trace_pc,         32'd0);
    check({tag, "_inst"},     trace_inst,       32'd0);
    check({tag, "_alu"},      trace_alu,        32'd0);
  endtask

  initial begin
    Reset       = 1'b1;
    start       = 1'b0;
    clear       = 1'b0;
    pc_q        = '0;
    pc_d        = '0;
    inst        = '0;
    alu_result  = '0;
    trace_ready = 1'b0;
    #2;
    check_reset_values("rst");
    @(negedge CLK);
    Reset = 1'b0;

    // Basic capture with a consumer that is always ready.
    step(1'b1, 1'b0, 32'h0, 32'h4, 1'b1);
    check("idle_no_push", 32'(count), 32'd0);
    step(1'b0, 1'b0, 32'h0, 32'h4, 1'b1);
    check("cap0_valid", 32'(trace_valid), 32'd1);
    check("cap0_pc",    trace_pc,         32'h0);
    check("cap0_count", 32'(count),       32'd1);
    step(1'b0, 1'b0, 32'h4, 32'h8, 1'b1);
    check("cap4_pc",    trace_pc,         32'h4);
    check("cap4_count", 32'(count),       32'd1);
    step(1'b0, 1'b0, 32'h8, 32'hC, 1'b1);
    check("cap8_pc",    trace_pc,         32'h8);
    check("cap8_inst",  trace_inst,       32'h1300_0008);
    check("cap8_alu",   trace_alu,        32'h0000_1008);
    check("cap8_count", 32'(count),       32'd1);
    step(1'b0, 1'b1, 32'hC, 32'h10, 1'b1);
    check("clr1_count", 32'(count),       32'd0);
    check("clr1_valid", 32'(trace_valid), 32'd0);
    step(1'b0, 1'b0, 32'hC, 32'h10, 1'b0);
    check("idle_again", 32'(count),       32'd0);

    // Halt detect: two ordinary records, then a self-loop at 0x20.
    step(1'b1, 1'b0, 32'h14, 32'h18, 1'b0);
    check("halt_start", 32'(count), 32'd0);
    step(1'b0, 1'b0, 32'h18, 32'h1C, 1'b0);
    check("halt_c1", 32'(count), 32'd1);
    step(1'b0, 1'b0, 32'h1C, 32'h20, 1'b0);
    check("halt_c2", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h20, 32'h20, 1'b0);
      check($sformatf("loop%0d_count", i),  32'(count),  32'(3 + i));
      check($sformatf("loop%0d_halted", i), 32'(halted), 32'd0);
    end
    step(1'b0, 1'b0, 32'h20, 32'h20, 1'b0);
    check("halt_count",  32'(count),  32'd5);
    check("halt_halted", 32'(halted), 32'd1);
    step(1'b0, 1'b0, 32'h20, 32'h20, 1'b0);
    check("halted_nopush", 32'(count), 32'd5);
    step(1'b1, 1'b0, 32'h20, 32'h20, 1'b0);
    check("halted_start_count",  32'(count),  32'd5);
    check("halted_start_halted", 32'(halted), 32'd1);
    check("halted_head_pc",      trace_pc,    32'h18);

    // Clear out of HALTED with 5 records queued.
    step(1'b0, 1'b1, 32'h20, 32'h20, 1'b1);
    check("clr_count",   32'(count),       32'd0);
    check("clr_valid",   32'(trace_valid), 32'd0);
    check("clr_halted",  32'(halted),      32'd0);
    check("clr_dropped", 32'(dropped),     32'd0);
    step(1'b0, 1'b0, 32'h24, 32'h28, 1'b0);
    check("clr_idle", 32'(count), 32'd0);
    step(1'b1, 1'b0, 32'h28, 32'h2C, 1'b0);
    step(1'b0, 1'b1, 32'h30, 32'h34, 1'b0);
    check("clr_cap_nopush", 32'(count),       32'd0);
    check("clr_cap_valid",  32'(trace_valid), 32'd0);
    step(1'b0, 1'b0, 32'h34, 32'h38, 1'b0);
    check("clr_cap_idle", 32'(count), 32'd0);

    // Overflow: 20 capture cycles into a 16-deep FIFO with no consumer.
    step(1'b1, 1'b0, 32'hF0, 32'hF4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 1'b0);
      if (i == 15) begin
        check("full_count",    32'(count),    32'd16);
        check("full_overflow", 32'(overflow), 32'd0);
        check("full_dropped",  32'(dropped),  32'd0);
      end
    end
    check("ovf_count",    32'(count),    32'd16);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_dropped",  32'(dropped),  32'd4);
    check("ovf_head_pc",  trace_pc,      32'h100);
    check("ovf_head_inst", trace_inst,   32'h1300_0100);
    check("ovf_head_alu", trace_alu,     32'h0000_1100);

    // Push and pop together on a full FIFO.
    step(1'b0, 1'b0, 32'h150, 32'h154, 1'b1);
    check("pp_count",    32'(count),    32'd16);
    check("pp_dropped",  32'(dropped),  32'd4);
    check("pp_overflow", 32'(overflow), 32'd1);
    check("pp_head_pc",  trace_pc,      32'h104);

    // Asynchronous reset in the middle of a capture cycle.
    trace_ready = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    check_reset_values("arst");
    #2;
    Reset = 1'b0;
    step(1'b0, 1'b0, 32'h200, 32'h204, 1'b0);
    check("arst_idle_count",  32'(count),  32'd0);
    check("arst_idle_halted", 32'(halted), 32'd0);
    step(1'b1, 1'b0, 32'h204, 32'h208, 1'b0);
    check("arst_start_count", 32'(count), 32'd0);
    step(1'b0, 1'b0, 32'h208, 32'h20C, 1'b0);
    check("arst_cap_count", 32'(count), 32'd1);
    check("arst_cap_pc",    trace_pc,   32'h208);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
